// File: rtl/dma_steal_arb.sv
// Cycle-steal arbiter granting BDMA/IDMA access to the core memory port.
// Define ARB_RR_EN for round-robin tie resolution; otherwise IDMA has fixed priority.
module dma_steal_arb (
  input  logic       DSPCLK,
  input  logic       RST,
  input  logic       BSreq,
  input  logic       IDreq,
  input  logic       CORE_lock,
  input  logic [3:0] BMAX,
  output logic       BSack,
  output logic       IDack,
  output logic       GO_STEAL,
  output logic       STEAL_src,
  output logic       ARB_busy
);

  typedef enum logic [1:0] {IDLE, GRANT, STEAL, YIELD} state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] steal_cnt;
  logic       any_req;
  logic       winner;
  logic       bs_ack_d;
  logic       id_ack_d;
  logic       go_d;
  logic       src_d;
  logic       busy_d;

  assign any_req = BSreq | IDreq;

`ifdef ARB_RR_EN
  // rr_ptr remembers the last served source; on a tie the other one wins.
  logic rr_ptr;

  always_comb begin
    if (BSreq && IDreq) winner = ~rr_ptr;
    else                winner = IDreq;
  end

  always_ff @(posedge DSPCLK or posedge RST) begin
    if (RST)                      rr_ptr <= 1'b0;
    else if (next_state == GRANT) rr_ptr <= winner;
  end
`else
  assign winner = IDreq;
`endif

  always_ff @(posedge DSPCLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Counts steals in the current burst; GRANT always leads to STEAL, so bump on leaving GRANT.
  always_ff @(posedge DSPCLK or posedge RST) begin
    if (RST)
      steal_cnt <= 4'd0;
    else if (state == IDLE || state == YIELD)
      steal_cnt <= 4'd0;
    else if (state == GRANT && steal_cnt != 4'hF)
      steal_cnt <= steal_cnt + 4'd1;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = (any_req && !CORE_lock) ? GRANT : IDLE;
      GRANT:   next_state = STEAL;
      STEAL: begin
        if (BMAX != 4'd0 && steal_cnt == BMAX) next_state = YIELD;
        else if (any_req && !CORE_lock)        next_state = GRANT;
        else                                   next_state = IDLE;
      end
      YIELD:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so every port comes straight off a flop.
  always_comb begin
    bs_ack_d = (next_state == GRANT) && !winner;
    id_ack_d = (next_state == GRANT) && winner;
    go_d     = (next_state == GRANT) || (next_state == STEAL);
    busy_d   = (next_state != IDLE);
    src_d    = (next_state == GRANT) ? winner : STEAL_src;
  end

  always_ff @(posedge DSPCLK or posedge RST) begin
    if (RST) begin
      BSack     <= 1'b0;
      IDack     <= 1'b0;
      GO_STEAL  <= 1'b0;
      STEAL_src <= 1'b0;
      ARB_busy  <= 1'b0;
    end else begin
      BSack     <= bs_ack_d;
      IDack     <= id_ack_d;
      GO_STEAL  <= go_d;
      STEAL_src <= src_d;
      ARB_busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_dma_steal_arb.sv
// Scoreboard bench for dma_steal_arb: stimulus queues expected output vectors,
// a negedge monitor pops and compares {BSack, IDack, GO_STEAL, STEAL_src, ARB_busy}.
module tb_dma_steal_arb;

  logic       DSPCLK;
  logic       RST;
  logic       BSreq;
  logic       IDreq;
  logic       CORE_lock;
  logic [3:0] BMAX;
  logic       BSack;
  logic       IDack;
  logic       GO_STEAL;
  logic       STEAL_src;
  logic       ARB_busy;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int         due;
    int         idx;
    logic [4:0] exp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vec_idx = 0;
  int   vectors = 0;
  int   miscompares = 0;

  dma_steal_arb dut (
    .DSPCLK    (DSPCLK),
    .RST       (RST),
    .BSreq     (BSreq),
    .IDreq     (IDreq),
    .CORE_lock (CORE_lock),
    .BMAX      (BMAX),
    .BSack     (BSack),
    .IDack     (IDack),
    .GO_STEAL  (GO_STEAL),
    .STEAL_src (STEAL_src),
    .ARB_busy  (ARB_busy)
  );

  initial begin
    DSPCLK = 1'b0;
    forever #5 DSPCLK = ~DSPCLK;
  end

  initial forever begin
    @(posedge DSPCLK);
    cyc++;
  end

  // Output vector encodings: {BSack, IDack, GO_STEAL, STEAL_src, ARB_busy}
  function automatic logic [4:0] g(bit s);
    return s ? 5'b01111 : 5'b10101;
  endfunction
  function automatic logic [4:0] st(bit s);
    return {3'b001, s, 1'b1};
  endfunction
  function automatic logic [4:0] idl(bit s);
    return {3'b000, s, 1'b0};
  endfunction
  function automatic logic [4:0] yl(bit s);
    return {3'b000, s, 1'b1};
  endfunction

  task automatic pushExp(input int due, input logic [4:0] exp);
    exp_t e;
    e.due = due;
    e.idx = vec_idx;
    e.exp = exp;
    vec_idx++;
    q.push_back(e);
  endtask

  // Drive inputs just after an edge; the response is expected after the following edge.
  task automatic applyStimulus(input logic bs, input logic id, input logic lock,
                               input logic [3:0] bmax, input logic [4:0] exp);
    @(posedge DSPCLK);
    #1;
    BSreq     = bs;
    IDreq     = id;
    CORE_lock = lock;
    BMAX      = bmax;
    pushExp(cyc + 1, exp);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] act;
    act = {BSack, IDack, GO_STEAL, STEAL_src, ARB_busy};
    vectors++;
    if (e.due != cyc) begin
      miscompares++;
      $display("[TB] FAIL vec %0d: checked in cycle %0d, required cycle %0d", e.idx, cyc, e.due);
    end else if (act !== e.exp) begin
      miscompares++;
      $display("[TB] FAIL vec %0d: {BSack,IDack,GO,src,busy} actual %b required %b (cycle %0d)",
               e.idx, act, e.exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge DSPCLK);
    while (q.size() > 0 && q[0].due <= cyc) checkOutput(q.pop_front());
  end

  initial begin
    RST = 1'b1; BSreq = 1'b0; IDreq = 1'b0; CORE_lock = 1'b0; BMAX = 4'd0;
    @(posedge DSPCLK); #1;
    pushExp(cyc, 5'b00000);
    @(posedge DSPCLK); #1;
    RST = 1'b0;

    // single BDMA request
    applyStimulus(0, 0, 0, 0, idl(0));
    applyStimulus(1, 0, 0, 0, g(0));
    applyStimulus(0, 0, 0, 0, st(0));
    applyStimulus(0, 0, 0, 0, idl(0));

    // both requests held, unlimited bursts
    applyStimulus(1, 1, 0, 0, g(1));
    applyStimulus(1, 1, 0, 0, st(1));
    applyStimulus(1, 1, 0, 0, g(!RR));
    applyStimulus(1, 1, 0, 0, st(!RR));
    applyStimulus(1, 0, 0, 0, g(0));
    applyStimulus(0, 0, 0, 0, st(0));
    applyStimulus(0, 0, 0, 0, idl(0));

    // BMAX = 3: three steals, YIELD, IDLE, burst resumes
    applyStimulus(1, 1, 0, 3, g(1));
    applyStimulus(1, 1, 0, 3, st(1));
    applyStimulus(1, 1, 0, 3, g(!RR));
    applyStimulus(1, 1, 0, 3, st(!RR));
    applyStimulus(1, 1, 0, 3, g(1));
    applyStimulus(1, 1, 0, 3, st(1));
    applyStimulus(1, 1, 0, 3, yl(1));
    applyStimulus(1, 1, 0, 3, idl(1));
    applyStimulus(1, 1, 0, 3, g(!RR));
    applyStimulus(0, 0, 0, 3, st(!RR));
    applyStimulus(0, 0, 0, 3, idl(!RR));

    // CORE_lock raised mid-steal
    applyStimulus(1, 0, 0, 0, g(0));
    applyStimulus(1, 0, 1, 0, st(0));
    applyStimulus(1, 0, 1, 0, idl(0));
    applyStimulus(1, 0, 1, 0, idl(0));
    applyStimulus(1, 0, 0, 0, g(0));
    applyStimulus(0, 0, 0, 0, st(0));
    applyStimulus(0, 0, 0, 0, idl(0));

    // BMAX lowered below the running count: no yield until the counter clears
    applyStimulus(0, 1, 0, 0, g(1));
    applyStimulus(0, 1, 0, 0, st(1));
    applyStimulus(0, 1, 0, 0, g(1));
    applyStimulus(0, 1, 0, 0, st(1));
    applyStimulus(0, 1, 0, 1, g(1));
    applyStimulus(0, 1, 0, 1, st(1));
    applyStimulus(0, 0, 0, 1, idl(1));
    applyStimulus(0, 1, 0, 1, g(1));
    applyStimulus(0, 1, 0, 1, st(1));
    applyStimulus(0, 1, 0, 1, yl(1));
    applyStimulus(0, 0, 0, 0, idl(1));

    // reset asserted while in GRANT, then a fresh request after release
    @(posedge DSPCLK); #1;
    BSreq = 1'b1;
    @(posedge DSPCLK); #2;
    RST = 1'b1;
    pushExp(cyc, 5'b00000);
    @(posedge DSPCLK); #1;
    RST = 1'b0;
    pushExp(cyc, 5'b00000);
    pushExp(cyc + 1, g(0));
    applyStimulus(0, 0, 0, 0, st(0));
    applyStimulus(0, 0, 0, 0, idl(0));

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge DSPCLK);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL vec %0d: never checked, required %b by cycle %0d", e.idx, e.exp, e.due);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
